m_calc_engine: RTL and testbench

M_CALC_ENGINE -- requirements
Module: m_calc_engine

---
 rtl/m_calc_engine_if.sv | 30 +++
 rtl/m_calc_engine.sv | 92 +++++++++
 tb/tb_m_calc_engine.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/m_calc_engine_if.sv
// Host-side bundle for m_calc_engine: calculate handshake, sample/coefficient
// write ports and the registered result outputs.
interface m_calc_engine_if #(
  parameter int CGES = 7,
  parameter int DW   = 16
);
  localparam int AW = $clog2(CGES);
  localparam int RW = 2*DW + AW;

  logic                 cal;
  logic                 din_valid;
  logic signed [DW-1:0] din;
  logic                 coef_wr;
  logic [AW-1:0]        coef_addr;
  logic signed [DW-1:0] coef_data;
  logic                 fin;
  logic signed [RW-1:0] result;
  logic                 result_valid;
  logic                 busy;

  modport master (
    output cal, din_valid, din, coef_wr, coef_addr, coef_data,
    input  fin, result, result_valid, busy
  );

  modport slave (
    input  cal, din_valid, din, coef_wr, coef_addr, coef_data,
    output fin, result, result_valid, busy
  );
endinterface

// File: rtl/m_calc_engine.sv
// Sequential CGES-tap dot product: one multiply-accumulate per cycle over a
// sample shift register and a coefficient file, with abortable runs.
module m_calc_engine #(
  parameter int CGES = 7,
  parameter int DW   = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  m_calc_engine_if.slave bus
);
  localparam int AW = $clog2(CGES);
  localparam int RW = 2*DW + AW;
  localparam logic [AW-1:0] LAST = AW'(CGES-1);
  localparam logic [AW:0]   NTAP = (AW+1)'(CGES);

  typedef enum logic [1:0] {IDLE, RUN, DONE, HOLD} state_t;

  state_t                  r_state, w_next;
  logic [AW-1:0]           r_idx;
  logic signed [RW-1:0]    r_acc, r_result;
  logic                    r_fin, r_busy, r_rv;
  logic [CGES-1:0][DW-1:0] r_sample, r_coef;

  logic                    w_start, w_step, w_fin_d, w_busy_d, w_wr_en, w_coef_ok;
  logic signed [2*DW-1:0]  w_prod;

  always_ff @(posedge clk) begin
    if (reset_n) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Abort has priority over completion on the last tap.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.cal) w_next = RUN;
      RUN:     if (!bus.cal)          w_next = IDLE;
               else if (r_idx == LAST) w_next = DONE;
      DONE:    w_next = HOLD;
      HOLD:    if (!bus.cal) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_start  = (r_state == IDLE) && bus.cal;
    w_step   = (r_state == RUN)  && bus.cal;
    w_fin_d  = (r_state == DONE);
    w_busy_d = (w_next == RUN) || (w_next == DONE);
    w_wr_en  = (r_state == IDLE) || (r_state == HOLD);
  end

  assign w_coef_ok = {1'b0, bus.coef_addr} < NTAP;
  assign w_prod    = $signed(r_sample[r_idx]) * $signed(r_coef[r_idx]);

  always_ff @(posedge clk) begin
    if (reset_n) begin
      r_idx    <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_fin    <= 1'b0;
      r_busy   <= 1'b0;
      r_rv     <= 1'b0;
      r_sample <= '0;
      r_coef   <= '0;
    end else begin
      r_fin  <= w_fin_d;
      r_busy <= w_busy_d;
      if (w_start) begin
        r_acc <= '0;
        r_idx <= '0;
        r_rv  <= 1'b0;
      end else if (w_step) begin
        r_acc <= r_acc + RW'(w_prod);
        r_idx <= r_idx + AW'(1);
      end
      if (w_fin_d) begin
        r_result <= r_acc;
        r_rv     <= 1'b1;
      end
      if (w_wr_en && bus.din_valid)
        r_sample <= {r_sample[CGES-2:0], bus.din};
      if (w_wr_en && bus.coef_wr && w_coef_ok)
        r_coef[bus.coef_addr] <= bus.coef_data;
    end
  end

  assign bus.fin          = r_fin;
  assign bus.result       = r_result;
  assign bus.result_valid = r_rv;
  assign bus.busy         = r_busy;
endmodule

// File: tb/tb_m_calc_engine.sv
// Bench for m_calc_engine: directed vector table, abort/hold/reset sequences
// and randomized loads checked against a queue-based dot-product model.
module tb_m_calc_engine;
  localparam int CGES = 7;
  localparam int DW   = 16;

  logic clk, reset_n;
  int   n_chk = 0, n_fail = 0;

  m_calc_engine_if #(.CGES(CGES), .DW(DW)) bus();
  m_calc_engine #(.CGES(CGES), .DW(DW)) u_dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct packed {
    logic [CGES-1:0][DW-1:0] s;
    logic [CGES-1:0][DW-1:0] c;
    logic [63:0]             exp;
  } vec_t;

  longint smp_q[$];
  longint coef_m[CGES];
  longint last_res;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  function automatic longint model_dot();
    longint sum = 0;
    for (int i = 0; i < CGES; i++) sum += smp_q[i] * coef_m[i];
    return sum;
  endfunction

  task automatic model_clear();
    smp_q = {};
    for (int i = 0; i < CGES; i++) begin
      smp_q.push_back(0);
      coef_m[i] = 0;
    end
  endtask

  // One idle-cycle write; both strobes act independently.
  task automatic wr(input bit dv, input logic [DW-1:0] d, input bit cw,
                    input logic [2:0] a, input logic [DW-1:0] cd);
    bus.din_valid = dv; bus.din = d;
    bus.coef_wr = cw; bus.coef_addr = a; bus.coef_data = cd;
    @(negedge clk);
    bus.din_valid = 0; bus.coef_wr = 0;
    if (dv) begin
      smp_q.push_front(longint'($signed(d)));
      void'(smp_q.pop_back());
    end
    if (cw && a < CGES) coef_m[a] = longint'($signed(cd));
  endtask

  task automatic do_run(input longint exp, input int hold, input bit poke, input string nm);
    int n = 0, fins = 0;
    bit seen = 0;
    bus.cal = 1;
    while (n < 40 && !seen) begin
      @(negedge clk); n++;
      if (poke && n >= 2 && n <= 5) begin
        bus.din_valid = 1; bus.din = 16'h1234;
        bus.coef_wr = 1; bus.coef_addr = 3'(n); bus.coef_data = 16'h7777;
      end else begin
        bus.din_valid = 0; bus.coef_wr = 0;
      end
      if (bus.fin) seen = 1;
      else if (n == 1) begin
        chk({nm, " busy_in_run"}, longint'(bus.busy), 1);
        chk({nm, " rv_cleared"}, longint'(bus.result_valid), 0);
      end
    end
    bus.din_valid = 0; bus.coef_wr = 0;
    chk({nm, " fin_latency"}, seen ? n : -1, CGES + 2);
    chk({nm, " result"}, longint'(bus.result), exp);
    chk({nm, " result_valid"}, longint'(bus.result_valid), 1);
    for (int k = 0; k <= hold; k++) begin
      @(negedge clk);
      if (bus.fin) fins++;
    end
    chk({nm, " single_fin"}, fins, 0);
    bus.cal = 0;
    @(negedge clk); @(negedge clk);
    chk({nm, " result_kept"}, longint'(bus.result), exp);
    last_res = exp;
  endtask

  task automatic load_vec(input vec_t v);
    for (int i = 0; i < CGES; i++) wr(0, '0, 1, 3'(i), v.c[i]);
    for (int i = CGES-1; i >= 0; i--) wr(1, v.s[i], 0, '0, '0);
  endtask

  vec_t vt[4];

  initial begin
    bus.cal = 0; bus.din_valid = 0; bus.din = '0;
    bus.coef_wr = 0; bus.coef_addr = '0; bus.coef_data = '0;
    reset_n = 1;
    model_clear();
    last_res = 0;
    repeat (3) @(negedge clk);
    chk("rst fin", longint'(bus.fin), 0);
    chk("rst busy", longint'(bus.busy), 0);
    chk("rst result", longint'(bus.result), 0);
    chk("rst result_valid", longint'(bus.result_valid), 0);
    reset_n = 0;
    @(negedge clk);

    for (int i = 0; i < CGES; i++) begin
      vt[0].s[i] = 16'(i + 1);  vt[0].c[i] = 16'd1;
      vt[1].s[i] = '0;          vt[1].c[i] = '0;
      vt[2].s[i] = 16'h8000;    vt[2].c[i] = 16'h8000;
      vt[3].s[i] = 16'h7fff;    vt[3].c[i] = 16'h8000;
    end
    vt[0].exp = 64'd28;
    vt[1].s[0] = 16'd3; vt[1].c[0] = 16'hfffe; vt[1].exp = -64'sd6;
    vt[2].exp = 64'd7516192768;
    vt[3].exp = -64'sd7515963392;

    for (int v = 0; v < 4; v++) begin
      load_vec(vt[v]);
      do_run(longint'(vt[v].exp), 0, 0, $sformatf("vec%0d", v));
    end

    // Out-of-range coefficient write must not disturb the file.
    wr(0, '0, 1, 3'd7, 16'h1111);
    load_vec(vt[0]);
    do_run(28, 0, 0, "oob_addr");

    // Abort after three RUN cycles, then a clean rerun.
    wr(1, 16'd5, 1, 3'd2, 16'hfffd);
    bus.cal = 1;
    repeat (3) @(negedge clk);
    bus.cal = 0;
    begin
      int fins = 0;
      repeat (12) begin
        @(negedge clk);
        if (bus.fin) fins++;
      end
      chk("abort no_fin", fins, 0);
    end
    chk("abort result", longint'(bus.result), last_res);
    chk("abort rv", longint'(bus.result_valid), 0);
    chk("abort busy", longint'(bus.busy), 0);
    do_run(model_dot(), 0, 0, "after_abort");

    // Hold cal after fin; writes during RUN are dropped.
    do_run(model_dot(), 3, 1, "hold_poke");
    do_run(model_dot(), 0, 0, "post_poke");

    // Reset in the middle of a run.
    bus.cal = 1;
    repeat (4) @(negedge clk);
    reset_n = 1; bus.cal = 0;
    @(negedge clk);
    reset_n = 0;
    model_clear();
    chk("midrst fin", longint'(bus.fin), 0);
    chk("midrst busy", longint'(bus.busy), 0);
    chk("midrst result", longint'(bus.result), 0);
    chk("midrst rv", longint'(bus.result_valid), 0);
    @(negedge clk);
    do_run(0, 0, 0, "after_rst");

    for (int it = 0; it < 15; it++) begin
      int nw = $urandom_range(1, 10);
      for (int k = 0; k < nw; k++)
        wr(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), 16'($urandom));
      do_run(model_dot(), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
             $sformatf("rnd%0d", it));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
